// File: rtl/bcd_round_ctrl_if.sv
// Signal bundle between the round controller and its neighbours: the BCD RNG,
// the keypad decoder and the display/LED logic.
interface bcd_round_ctrl_if;
   logic        start;
   logic        fetch_num;
   logic [3:0]  rng_d1000;
   logic [3:0]  rng_d100;
   logic [3:0]  rng_d10;
   logic [3:0]  rng_d1;
   logic        key_valid;
   logic [3:0]  key_digit;
   logic        key_enter;
   logic        key_clear;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [19:0] sum;
   logic [19:0] ans;
   logic        entry_active;
   logic        result_valid;
   logic        correct;
   logic        timed_out;
   logic [7:0]  score;
   logic [3:0]  round;
   logic        game_over;

   // Controller side.
   modport slave (
      input  start, rng_d1000, rng_d100, rng_d10, rng_d1,
             key_valid, key_digit, key_enter, key_clear,
      output fetch_num, op_a, op_b, sum, ans, entry_active, result_valid,
             correct, timed_out, score, round, game_over
   );

   // Environment side: RNG, keypad and display.
   modport master (
      output start, rng_d1000, rng_d100, rng_d10, rng_d1,
             key_valid, key_digit, key_enter, key_clear,
      input  fetch_num, op_a, op_b, sum, ans, entry_active, result_valid,
             correct, timed_out, score, round, game_over
   );
endinterface

// File: rtl/bcd_round_ctrl.sv
// Round controller for the BCD math game: fetches two operands from the RNG,
// adds them in BCD, times and grades the keypad answer, and keeps the score.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | after reset, waiting for start
// FETCH_A | fetch_num pulse for operand A
// CAP_A   | RNG digits valid, capture op_a (saturated to 9)
// FETCH_B | fetch_num pulse for operand B
// CAP_B   | capture op_b
// ADD     | register BCD sum, clear answer entry and load timer
// ENTRY   | player keys the answer; timer running
// CHECK   | grade answer, update score and round count
// RESULT  | result_valid pulse; choose next round or game over
// DONE    | game over, everything held until start
module bcd_round_ctrl #(
   parameter int unsigned ROUNDS         = 10,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input logic            clk,
   input logic            rst,
   bcd_round_ctrl_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH_A = 4'd1,
      S_CAP_A   = 4'd2,
      S_FETCH_B = 4'd3,
      S_CAP_B   = 4'd4,
      S_ADD     = 4'd5,
      S_ENTRY   = 4'd6,
      S_CHECK   = 4'd7,
      S_RESULT  = 4'd8,
      S_DONE    = 4'd9
   } state_t;

   // The timer counts down from TIMEOUT_CYCLES-1; expiry is the zero terminal count.
   localparam logic [25:0] TMR_LOAD = 26'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  ROUNDS_L = 4'(ROUNDS);

   state_t      state_q, state_d;
   logic [15:0] op_a_q, op_a_d;
   logic [15:0] op_b_q, op_b_d;
   logic [19:0] sum_q, sum_d;
   logic [19:0] ans_q, ans_d;
   logic [2:0]  dig_cnt_q, dig_cnt_d;
   logic [25:0] tmr_q, tmr_d;
   logic        to_flag_q, to_flag_d;
   logic        correct_q, correct_d;
   logic        timed_out_q, timed_out_d;
   logic [7:0]  score_q, score_d;
   logic [3:0]  round_q, round_d;
   logic [15:0] rng_sat;

   function automatic logic [3:0] sat9(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   // Four-digit BCD ripple add; the fifth digit is the final carry.
   function automatic logic [19:0] bcd_add4(input logic [15:0] a, input logic [15:0] b);
      logic [4:0]  s;
      logic        c;
      logic [19:0] r;
      c = 1'b0;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
         if (s > 5'd9) begin
            s = s + 5'd6;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         r[4*i +: 4] = s[3:0];
      end
      r[19:16] = {3'd0, c};
      return r;
   endfunction

   function automatic logic [7:0] bcd_inc2(input logic [7:0] s);
      logic [7:0] r;
      if (s[3:0] >= 4'd9) begin
         r[3:0] = 4'd0;
         r[7:4] = (s[7:4] >= 4'd9) ? 4'd0 : s[7:4] + 4'd1;
      end else begin
         r = {s[7:4], s[3:0] + 4'd1};
      end
      return r;
   endfunction

   assign rng_sat = {sat9(bus.rng_d1000), sat9(bus.rng_d100),
                     sat9(bus.rng_d10),   sat9(bus.rng_d1)};

   // Next-state and register update logic.
   always_comb begin
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      sum_d       = sum_q;
      ans_d       = ans_q;
      dig_cnt_d   = dig_cnt_q;
      tmr_d       = tmr_q;
      to_flag_d   = to_flag_q;
      correct_d   = correct_q;
      timed_out_d = timed_out_q;
      score_d     = score_q;
      round_d     = round_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d     = S_FETCH_A;
               score_d     = 8'd0;
               round_d     = 4'd0;
               correct_d   = 1'b0;
               timed_out_d = 1'b0;
               ans_d       = 20'd0;
               dig_cnt_d   = 3'd0;
            end
         end
         S_FETCH_A: state_d = S_CAP_A;
         S_CAP_A: begin
            op_a_d  = rng_sat;
            state_d = S_FETCH_B;
         end
         S_FETCH_B: state_d = S_CAP_B;
         S_CAP_B: begin
            op_b_d  = rng_sat;
            state_d = S_ADD;
         end
         S_ADD: begin
            sum_d     = bcd_add4(op_a_q, op_b_q);
            ans_d     = 20'd0;
            dig_cnt_d = 3'd0;
            tmr_d     = TMR_LOAD;
            to_flag_d = 1'b0;
            state_d   = S_ENTRY;
         end
         S_ENTRY: begin
            // Saturate at zero so a clear on the expiry cycle still times out next cycle.
            if (tmr_q != 26'd0) begin
               tmr_d = tmr_q - 26'd1;
            end
            if (bus.key_clear) begin
               ans_d     = 20'd0;
               dig_cnt_d = 3'd0;
            end else if (bus.key_enter) begin
               to_flag_d = 1'b0;
               state_d   = S_CHECK;
            end else if (tmr_q == 26'd0) begin
               to_flag_d = 1'b1;
               state_d   = S_CHECK;
            end else if (bus.key_valid && (bus.key_digit <= 4'd9) && (dig_cnt_q < 3'd5)) begin
               ans_d     = {ans_q[15:0], bus.key_digit};
               dig_cnt_d = dig_cnt_q + 3'd1;
            end
         end
         S_CHECK: begin
            correct_d   = (ans_q == sum_q) && !to_flag_q;
            timed_out_d = to_flag_q;
            if ((ans_q == sum_q) && !to_flag_q) begin
               score_d = bcd_inc2(score_q);
            end
            round_d = round_q + 4'd1;
            state_d = S_RESULT;
         end
         S_RESULT: begin
            state_d = (round_q == ROUNDS_L) ? S_DONE : S_FETCH_A;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Register bank with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         sum_q       <= '0;
         ans_q       <= '0;
         dig_cnt_q   <= '0;
         tmr_q       <= '0;
         to_flag_q   <= 1'b0;
         correct_q   <= 1'b0;
         timed_out_q <= 1'b0;
         score_q     <= '0;
         round_q     <= '0;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         sum_q       <= sum_d;
         ans_q       <= ans_d;
         dig_cnt_q   <= dig_cnt_d;
         tmr_q       <= tmr_d;
         to_flag_q   <= to_flag_d;
         correct_q   <= correct_d;
         timed_out_q <= timed_out_d;
         score_q     <= score_d;
         round_q     <= round_d;
      end
   end

   assign bus.fetch_num    = (state_q == S_FETCH_A) || (state_q == S_FETCH_B);
   assign bus.entry_active = (state_q == S_ENTRY);
   assign bus.result_valid = (state_q == S_RESULT);
   assign bus.game_over    = (state_q == S_DONE);
   assign bus.op_a         = op_a_q;
   assign bus.op_b         = op_b_q;
   assign bus.sum          = sum_q;
   assign bus.ans          = ans_q;
   assign bus.correct      = correct_q;
   assign bus.timed_out    = timed_out_q;
   assign bus.score        = score_q;
   assign bus.round        = round_q;

endmodule

// File: tb/tb_bcd_round_ctrl.sv
// Directed bench for bcd_round_ctrl with a small RNG model driven from a table.
module tb_bcd_round_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   fetch_cnt = 0;
   int   rv_cnt = 0;
   int   rng_ptr = 0;
   int   n;
   logic [15:0] rng_tab [0:63];

   always #5 clk = ~clk;

   bcd_round_ctrl_if bus();

   bcd_round_ctrl #(.ROUNDS(10), .TIMEOUT_CYCLES(20)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // RNG model: registers the next table entry on the edge that sees fetch_num.
   always @(posedge clk) begin
      if (bus.fetch_num === 1'b1) begin
         {bus.rng_d1000, bus.rng_d100, bus.rng_d10, bus.rng_d1} <= rng_tab[rng_ptr];
         rng_ptr   <= rng_ptr + 1;
         fetch_cnt <= fetch_cnt + 1;
      end
      if (bus.result_valid === 1'b1) rv_cnt <= rv_cnt + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] all_outs();
      return {38'd0, bus.fetch_num, bus.op_a, bus.op_b, bus.sum, bus.ans,
              bus.entry_active, bus.result_valid, bus.correct, bus.timed_out,
              bus.score, bus.round, bus.game_over};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic key(input logic [3:0] d);
      bus.key_valid = 1'b1;
      bus.key_digit = d;
      tick();
      bus.key_valid = 1'b0;
      bus.key_digit = 4'd0;
   endtask

   task automatic enter();
      bus.key_enter = 1'b1;
      tick();
      bus.key_enter = 1'b0;
   endtask

   task automatic start_game();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_entry(input string tag);
      int k = 0;
      while (bus.entry_active !== 1'b1 && k < 40) begin
         tick();
         k++;
      end
      check(tag, bus.entry_active, 1);
   endtask

   task automatic wait_result(input string tag);
      int k = 0;
      while (bus.result_valid !== 1'b1 && k < 60) begin
         tick();
         k++;
      end
      check(tag, bus.result_valid, 1);
   endtask

   // Zero-operand round answered with enter on the first ENTRY cycle (ans=0 matches).
   task automatic fast_round(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
         if (bus.entry_active === 1'b1) begin
            bus.key_enter = 1'b1;
            tick();
            cyc++;
            bus.key_enter = 1'b0;
         end
      end while (bus.result_valid !== 1'b1 && cyc < 40);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rng_tab[i] = 16'h0000;
      rng_tab[0] = 16'h1234; rng_tab[1] = 16'h5678;
      rng_tab[2] = 16'h9999; rng_tab[3] = 16'h9999;
      rng_tab[4] = 16'h0001; rng_tab[5] = 16'h0002;
      rng_tab[6] = 16'hA0F3; rng_tab[7] = 16'h0007;
      rng_tab[8] = 16'h0000; rng_tab[9] = 16'h0005;
      {bus.rng_d1000, bus.rng_d100, bus.rng_d10, bus.rng_d1} = 16'h0000;
      bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_digit = 4'd0;
      bus.key_enter = 1'b0; bus.key_clear = 1'b0;

      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         bus.start     = 1'($urandom_range(0, 1));
         bus.key_valid = 1'($urandom_range(0, 1));
         bus.key_digit = 4'($urandom_range(0, 15));
         bus.key_enter = 1'($urandom_range(0, 1));
         bus.key_clear = 1'($urandom_range(0, 1));
         tick();
         check("rst_outs", all_outs(), 0);
      end
      bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_digit = 4'd0;
      bus.key_enter = 1'b0; bus.key_clear = 1'b0;
      rst = 1'b1;
      tick();
      check("idle_outs", all_outs(), 0);
      check("rst_no_fetch", fetch_cnt, 0);

      // Round 1: 1234 + 5678 = 06912, correct, with latency checks
      start_game();
      check("lat_fetch_a", bus.fetch_num, 1);
      tick();
      check("cap_a_nofetch", bus.fetch_num, 0);
      tick();
      check("lat_op_a", bus.op_a, 16'h1234);
      check("lat_fetch_b", bus.fetch_num, 1);
      tick(); tick();
      check("lat_op_b", bus.op_b, 16'h5678);
      tick();
      check("lat_sum", bus.sum, 20'h06912);
      check("lat_entry", bus.entry_active, 1);
      key(4'd6); key(4'd9); key(4'd1); key(4'd2);
      check("r1_ans", bus.ans, 20'h06912);
      enter();
      tick();
      check("r1_rv", bus.result_valid, 1);
      check("r1_correct", bus.correct, 1);
      check("r1_score", bus.score, 8'h01);
      check("r1_round", bus.round, 4'd1);
      check("r1_fetches", fetch_cnt, 2);
      tick();
      check("r1_rv_once", rv_cnt, 1);
      check("r1_next_fetch", bus.fetch_num, 1);

      // Round 2: 9999 + 9999 = 19998, wrong answer, 6th digit ignored
      wait_entry("r2_entry");
      check("r2_sum", bus.sum, 20'h19998);
      key(4'd1); key(4'd9); key(4'd9); key(4'd9); key(4'd7);
      check("r2_ans5", bus.ans, 20'h19997);
      key(4'd5);
      check("r2_ans6", bus.ans, 20'h19997);
      enter();
      wait_result("r2_rv");
      check("r2_correct", bus.correct, 0);
      check("r2_score", bus.score, 8'h01);
      check("r2_round", bus.round, 4'd2);

      // Round 3: 0001 + 0002, clear/enter/digit in one cycle
      wait_entry("r3_entry");
      check("r3_sum", bus.sum, 20'h00003);
      key(4'd3);
      check("r3_ans", bus.ans, 20'h00003);
      bus.key_clear = 1'b1; bus.key_enter = 1'b1; bus.key_valid = 1'b1; bus.key_digit = 4'hA;
      tick();
      bus.key_clear = 1'b0; bus.key_enter = 1'b0; bus.key_valid = 1'b0; bus.key_digit = 4'd0;
      check("prio_ans", bus.ans, 20'h0);
      check("prio_stay", bus.entry_active, 1);
      key(4'hB);
      check("bad_digit", bus.ans, 20'h0);
      key(4'd3);
      enter();
      wait_result("r3_rv");
      check("r3_correct", bus.correct, 1);
      check("r3_score", bus.score, 8'h02);

      // Round 4: saturated operand A0F3 -> 9093, plus 0007, timeout with no keys
      wait_entry("r4_entry");
      check("sat_op_a", bus.op_a, 16'h9093);
      check("r4_sum", bus.sum, 20'h09100);
      n = 0;
      while (bus.entry_active === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("to_len", n, 20);
      tick();
      check("r4_rv", bus.result_valid, 1);
      check("r4_timed_out", bus.timed_out, 1);
      check("r4_correct", bus.correct, 0);
      check("r4_score", bus.score, 8'h02);
      check("r4_round", bus.round, 4'd4);

      // Round 5: enter on the expiry cycle wins; start during ENTRY ignored
      wait_entry("r5_entry");
      key(4'd5);
      repeat (4) tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("start_ign_fetch", bus.fetch_num, 0);
      check("start_ign_entry", bus.entry_active, 1);
      repeat (13) tick();
      check("r5_last_entry", bus.entry_active, 1);
      enter();
      tick();
      check("r5_rv", bus.result_valid, 1);
      check("r5_correct", bus.correct, 1);
      check("r5_timed_out", bus.timed_out, 0);
      check("r5_score", bus.score, 8'h03);
      check("r5_round", bus.round, 4'd5);

      // Rounds 6..10: fast zero rounds, 8-cycle gap
      for (int r = 6; r <= 10; r++) begin
         fast_round(n);
         if (r == 6) check("gap", n, 8);
      end
      check("g1_score", bus.score, 8'h08);
      check("g1_round", bus.round, 4'd10);
      tick();
      check("g1_over", bus.game_over, 1);
      repeat (3) tick();
      check("g1_hold", {bus.game_over, bus.score, bus.round}, {1'b1, 8'h08, 4'd10});
      check("g1_fetches", fetch_cnt, 20);

      // Game 2: start from DONE, all correct, score 09 -> 10
      start_game();
      check("g2_fetch", bus.fetch_num, 1);
      check("g2_clear", {bus.score, bus.round, bus.game_over}, 13'd0);
      for (int r = 1; r <= 10; r++) begin
         fast_round(n);
         if (r == 9) check("g2_score9", bus.score, 8'h09);
         if (r == 10) check("g2_gap", n, 8);
      end
      check("g2_score10", bus.score, 8'h10);
      check("g2_round", bus.round, 4'd10);
      tick();
      check("g2_over", bus.game_over, 1);

      // Reset mid-round
      start_game();
      tick(); tick();
      rst = 1'b0;
      tick();
      check("midrst_outs", all_outs(), 0);
      rst = 1'b1;
      tick();
      check("midrst_idle", all_outs(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
